// File: rtl/dmux_feed_sched.sv
// dmux_feed_sched: FIFO-buffered word feeder for a 1:4 demux; define DMUX_FEED_RR_EN for round-robin sel
module dmux_feed_sched #(
  parameter int DW = 32,
  parameter int DEPTH = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic [1:0]    in_dest,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] dout,
  output logic [1:0]    sel,
  output logic          out_valid,
  input  logic [3:0]    ch_ready,
  output logic [AW:0]   level
);
`ifdef DMUX_FEED_RR_EN
  localparam int EW = DW;
`else
  localparam int EW = DW + 2;
`endif
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] wdata, head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_q, level_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [1:0] sel_q, sel_d, rr_q, rr_d;
  logic out_valid_q, out_valid_d, wr, xfer, load;
`ifdef DMUX_FEED_RR_EN
  logic unused_dest;
  assign unused_dest = ^in_dest;
  assign wdata = in_data;
`else
  assign wdata = {in_dest, in_data};
`endif
  assign in_ready = !rst && level_q != FULL;
  assign wr = in_valid && in_ready;
  assign xfer = out_valid_q && ch_ready[sel_q];
  assign load = level_q != '0 && (!out_valid_q || xfer);
  assign head = mem_q[rd_ptr_q];
  assign dout = dout_q;
  assign sel = sel_q;
  assign out_valid = out_valid_q;
  assign level = level_q;
  // storage array; no reset needed since level gates every read
  always_ff @(posedge clk) if (wr) mem_q[wr_ptr_q] <= wdata;
  // next state: pointers wrap naturally at DEPTH, output register loads from head or clears on drain
  always_comb begin
    wr_ptr_d = wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = load ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d = level_q + {{AW{1'b0}}, wr} - {{AW{1'b0}}, load};
    out_valid_d = load ? 1'b1 : xfer ? 1'b0 : out_valid_q;
    dout_d = load ? head[DW-1:0] : xfer ? '0 : dout_q;
`ifdef DMUX_FEED_RR_EN
    sel_d = load ? rr_q : xfer ? 2'b00 : sel_q;
    rr_d = load ? rr_q + 1'b1 : rr_q;
`else
    sel_d = load ? head[DW+:2] : xfer ? 2'b00 : sel_q;
    rr_d = 2'b00;
`endif
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
      out_valid_q <= 1'b0;
      dout_q <= '0;
      sel_q <= 2'b00;
      rr_q <= 2'b00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
      out_valid_q <= out_valid_d;
      dout_q <= dout_d;
      sel_q <= sel_d;
      rr_q <= rr_d;
    end
  end
endmodule

// File: tb/tb_dmux_feed_sched.sv
// tb_dmux_feed_sched: queue-model scoreboard plus directed literal checks for dmux_feed_sched
module tb_dmux_feed_sched;
`ifdef DMUX_FEED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, out_valid;
  logic [31:0] in_data = '0, dout;
  logic [1:0] in_dest = '0, sel;
  logic [3:0] ch_ready = '0;
  logic [2:0] level;
  int checks = 0, errors = 0;
  bit chk_en = 1'b0;
  logic [33:0] q[$];
  logic [33:0] e;
  logic mv = 1'b0, xf, ld, wr;
  logic [31:0] md = '0;
  logic [1:0] ms = '0, rr = '0;

  dmux_feed_sched dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_dest(in_dest), .in_valid(in_valid),
    .in_ready(in_ready), .dout(dout), .sel(sel), .out_valid(out_valid),
    .ch_ready(ch_ready), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] rr_sel(input int k, input logic [1:0] d);
    return RR ? 2'(k) : d;
  endfunction

  // scoreboard: compare current outputs, then advance the queue model with the inputs for the next edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid", 64'(out_valid), 64'(mv));
      chk("m_dout", 64'(dout), 64'(md));
      chk("m_sel", 64'(sel), 64'(ms));
      chk("m_level", 64'(level), 64'(q.size()));
      chk("m_ready", 64'(in_ready), 64'(!rst && q.size() != 4));
    end
    if (rst) begin
      q.delete();
      mv = 1'b0;
      md = '0;
      ms = '0;
      rr = '0;
    end else begin
      xf = mv && ch_ready[ms];
      ld = q.size() != 0 && (!mv || xf);
      wr = in_valid && q.size() != 4;
      if (ld) begin
        e = q.pop_front();
        mv = 1'b1;
        md = e[31:0];
        ms = RR ? rr : e[33:32];
        rr = rr + 2'd1;
      end else if (xf) begin
        mv = 1'b0;
        md = '0;
        ms = '0;
      end
      if (wr) q.push_back({in_dest, in_data});
    end
  end

  initial begin
    tick();
    tick();
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_dout", 64'(dout), 0);
    chk("rst_sel", 64'(sel), 0);
    chk("rst_level", 64'(level), 0);
    chk("rst_ready", 64'(in_ready), 0);
    chk_en = 1'b1;
    rst = 1'b0;
    #1;
    chk("rdy_after_rst", 64'(in_ready), 1);
    in_data = 32'hDEADBEEF;
    in_dest = 2'd2;
    in_valid = 1'b1;
    ch_ready = 4'b1111;
    tick();
    in_valid = 1'b0;
    chk("single_n_valid", 64'(out_valid), 0);
    chk("single_n_level", 64'(level), 1);
    tick();
    chk("single_n1_dout", 64'(dout), 64'h DEADBEEF);
    chk("single_n1_sel", 64'(sel), 64'(rr_sel(0, 2'd2)));
    chk("single_n1_valid", 64'(out_valid), 1);
    tick();
    chk("single_n2_valid", 64'(out_valid), 0);
    chk("single_n2_dout", 64'(dout), 0);
    ch_ready = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      in_data = 32'hA0 + 32'(i);
      in_dest = 2'(i);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("fill_level", 64'(level), 4);
    chk("fill_ready", 64'(in_ready), 0);
    chk("fill_dout", 64'(dout), 64'hA0);
    ch_ready = 4'b1111;
    tick();
    chk("drain1_dout", 64'(dout), 64'hA1);
    chk("drain1_sel", 64'(sel), 64'(rr_sel(2, 2'd1)));
    chk("drain1_ready", 64'(in_ready), 1);
    chk("drain1_level", 64'(level), 3);
    for (int i = 2; i < 5; i++) begin
      tick();
      chk("drain_dout", 64'(dout), 64'hA0 + 64'(i));
    end
    tick();
    chk("drain_end_valid", 64'(out_valid), 0);
    chk("drain_end_level", 64'(level), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ch_ready = RR ? 4'b1110 : 4'b1101;
    in_data = 32'h55;
    in_dest = 2'd1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("stall_valid", 64'(out_valid), 1);
      chk("stall_dout", 64'(dout), 64'h55);
      chk("stall_sel", 64'(sel), 64'(rr_sel(0, 2'd1)));
      if (i < 3) tick();
    end
    ch_ready = 4'b1111;
    tick();
    chk("stall_release", 64'(out_valid), 0);
    ch_ready = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'hC0 + 32'(i);
      in_dest = 2'(i);
      in_valid = 1'b1;
      tick();
    end
    chk("both_pre_level", 64'(level), 2);
    chk("both_pre_dout", 64'(dout), 64'hC0);
    ch_ready = 4'b1111;
    in_data = 32'hC3;
    tick();
    chk("both_level", 64'(level), 2);
    chk("both_dout", 64'(dout), 64'hC1);
    in_data = 32'hC4;
    tick();
    chk("both2_level", 64'(level), 2);
    chk("both2_dout", 64'(dout), 64'hC2);
    rst = 1'b1;
    tick();
    chk("midrst_valid", 64'(out_valid), 0);
    chk("midrst_level", 64'(level), 0);
    chk("midrst_dout", 64'(dout), 0);
    chk("midrst_ready", 64'(in_ready), 0);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_data = 32'hD0 + 32'(i);
      in_dest = 2'd3;
      in_valid = 1'b1;
      tick();
      if (i > 0) begin
        chk("seq_dout", 64'(dout), 64'hD0 + 64'(i - 1));
        chk("seq_sel", 64'(sel), 64'(rr_sel(i - 1, 2'd3)));
      end
    end
    in_valid = 1'b0;
    tick();
    chk("seq_last_dout", 64'(dout), 64'hD5);
    chk("seq_last_sel", 64'(sel), 64'(rr_sel(5, 2'd3)));
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
